glyph_streamer: RTL and testbench

Upstream feeder for the pixel serializer stage. It accepts 8-bit character codes, reads each code's 16×16 monochrome bitmap from an external synchronous glyph ROM one row per cycle, and assembles the bitmap into a 256-bit vector. It presents the vector on `char` with `printable` held high for exactly 256 cycles per glyph, so the serializer's 0..255 index walks the glyph once. A double-buffered design fetches the next glyph during display and gives gapless back-to-back output.

---
 rtl/glyph_pkg.sv | 19 +
 rtl/glyph_fetch.sv | 89 ++++++++
 rtl/glyph_streamer.sv | 80 ++++++++
 tb/tb_glyph_streamer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared glyph geometry constants and FSM state types
package glyph_pkg;

  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 16;
  localparam int GLYPH_BITS = GLYPH_ROWS * GLYPH_COLS;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_FULL
  } fetch_state_e;

  typedef enum logic {
    D_IDLE,
    D_SHOW
  } disp_state_e;

endpackage

// File: rtl/glyph_fetch.sv
// rtl/glyph_fetch.sv - fetches one glyph bitmap row by row from the ROM into a shadow buffer
module glyph_fetch
  import glyph_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int ROM_AW = CODE_W + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [CODE_W-1:0]     code_i,
  input  logic                  take_i,
  output logic                  ready_o,
  output logic                  full_o,
  output logic                  active_o,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [15:0]           rom_data_i,
  output logic [0:GLYPH_BITS-1] shadow_o
);

  fetch_state_e          state_q, state_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic [0:GLYPH_BITS-1] shadow_q, shadow_d;
  logic [3:0]            cap_row;

  // cnt_q counts cycles since accept; the ROM answers one cycle late, so cycle k captures row k-1
  assign cap_row = 4'(cnt_q - 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= F_IDLE;
      code_q     <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    shadow_d   = shadow_q;
    case (state_q)
      F_IDLE: begin
        if (start_i) begin
          state_d    = F_READ;
          code_d     = code_i;
          cnt_d      = '0;
          rom_addr_d = {code_i, 4'd0};
        end
      end
      F_READ: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q < 5'd15) begin
          rom_addr_d = {code_q, cnt_q[3:0] + 4'd1};
        end
        if (cnt_q != 5'd0) begin
          shadow_d[{cap_row, 4'h0} +: 16] = rom_data_i;
        end
        if (cnt_q == 5'd16) begin
          state_d = F_FULL;
        end
      end
      F_FULL: begin
        if (take_i) begin
          state_d = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign ready_o    = (state_q == F_IDLE) && !reset;
  assign full_o     = (state_q == F_FULL);
  assign active_o   = (state_q != F_IDLE);
  assign rom_addr_o = rom_addr_q;
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/glyph_streamer.sv
// rtl/glyph_streamer.sv - double-buffered glyph source: shows each glyph on char_o for exactly 256 cycles
module glyph_streamer
  import glyph_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int ROM_AW = CODE_W + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid_i,
  input  logic [CODE_W-1:0]     code_i,
  output logic                  code_ready_o,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [15:0]           rom_data_i,
  output logic [0:GLYPH_BITS-1] char_o,
  output logic                  printable_o,
  output logic                  busy_o
);

  disp_state_e           dstate_q, dstate_d;
  logic [7:0]            count_q, count_d;
  logic [0:GLYPH_BITS-1] char_q, char_d;
  logic [0:GLYPH_BITS-1] shadow;
  logic                  full, fetch_active, take, accept;

  assign accept = code_valid_i && code_ready_o;

  // A waiting glyph is taken when the display is free or on the last cycle of the current one
  assign take = full && ((dstate_q == D_IDLE) || (count_q == 8'hFF));

  glyph_fetch #(
    .CODE_W(CODE_W),
    .ROM_AW(ROM_AW)
  ) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept),
    .code_i    (code_i),
    .take_i    (take),
    .ready_o   (code_ready_o),
    .full_o    (full),
    .active_o  (fetch_active),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .shadow_o  (shadow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dstate_q <= D_IDLE;
      count_q  <= '0;
      char_q   <= '0;
    end else begin
      dstate_q <= dstate_d;
      count_q  <= count_d;
      char_q   <= char_d;
    end
  end

  always_comb begin
    dstate_d = dstate_q;
    count_d  = count_q;
    char_d   = char_q;
    if (take) begin
      char_d   = shadow;
      count_d  = '0;
      dstate_d = D_SHOW;
    end else if (dstate_q == D_SHOW) begin
      count_d = count_q + 8'd1;
      if (count_q == 8'hFF) begin
        dstate_d = D_IDLE;
      end
    end
  end

  assign char_o      = char_q;
  assign printable_o = (dstate_q == D_SHOW);
  assign busy_o      = printable_o || fetch_active;

endmodule

// File: tb/tb_glyph_streamer.sv
// tb/tb_glyph_streamer.sv - scoreboard bench: stimulus queues expected glyphs, a monitor checks each displayed glyph
module tb_glyph_streamer;

  typedef struct {
    logic [0:255] img;
    int           start;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         code_valid = 1'b0;
  logic [7:0]   code = 8'h00;
  logic         code_ready;
  logic [11:0]  rom_addr;
  logic [15:0]  rom_data = 16'h0000;
  logic [0:255] char_v;
  logic         printable;
  logic         busy;

  int   edge_n = 0;
  logic rst_at_edge = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];

  glyph_streamer #(.CODE_W(8), .ROM_AW(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid_i(code_valid),
    .code_i      (code),
    .code_ready_o(code_ready),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .char_o      (char_v),
    .printable_o (printable),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] c, input logic [3:0] r);
    return 16'hA5A5 ^ {c ^ 8'h41, 4'h0, r};
  endfunction

  function automatic logic [0:255] glyph(input logic [7:0] c);
    logic [0:255] g;
    for (int r = 0; r < 16; r++) g[r*16 +: 16] = rom_word(c, 4'(r));
    return g;
  endfunction

  always @(posedge clk) begin
    edge_n      <= edge_n + 1;
    rst_at_edge <= reset;
    rom_data    <= rom_word(rom_addr[11:4], rom_addr[3:0]);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: each new glyph (rising printable, or a fresh one after 256 cycles) pops one expectation
  logic         mon_prev = 1'b0;
  int           mon_run = 0;
  logic [0:255] mon_cur = '0;
  exp_t         mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        mon_prev = 1'b0;
        mon_run  = 0;
      end else begin
        if (printable && (!mon_prev || mon_run == 256)) begin
          check("glyph_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_cur = mon_e.img;
            check("glyph_char", char_v, mon_e.img);
            check("glyph_start_edge", edge_n, mon_e.start);
          end
          mon_run = 1;
        end else if (printable) begin
          mon_run++;
          if (mon_run == 256) check("glyph_char_stable", char_v, mon_cur);
        end else if (mon_prev) begin
          check("glyph_len", mon_run, 256);
          mon_run = 0;
        end
        mon_prev = printable;
      end
    end
  end

  task automatic send(input logic [7:0] c, output int acc);
    code       = c;
    code_valid = 1'b1;
    acc        = -1;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (code_ready) begin
        acc = edge_n + 1;
        break;
      end
      @(negedge clk);
    end
    check("accept_in_budget", acc >= 0, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] c, input int start);
    exp_t e;
    e.img   = glyph(c);
    e.start = start;
    exp_q.push_back(e);
  endtask

  initial begin
    int a0, a1, a2, bad;
    logic [0:255] w;
    logic [11:0] ea;

    repeat (3) @(negedge clk);
    check("ready_in_reset", code_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_ready", code_ready, 1'b1);
    check("rst_printable", printable, 1'b0);
    check("rst_char", char_v, 256'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_rom_addr", rom_addr, 12'h000);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (printable !== 1'b0 || char_v !== '0 || busy !== 1'b0 ||
          code_ready !== 1'b1 || rom_addr !== 12'h000) bad++;
    end
    check("idle_stable", bad, 0);

    // single glyph
    send(8'h41, a0);
    code_valid = 1'b0;
    push(8'h41, a0 + 18);
    check("busy_fetch", busy, 1'b1);
    for (int r = 0; r <= 16; r++) begin
      ea = {8'h41, 4'((r > 15) ? 15 : r)};
      check("rom_addr_row", rom_addr, ea);
      @(negedge clk);
    end
    wait_until(a0 + 17);
    check("no_early_show", printable, 1'b0);
    check("ready_while_full", code_ready, 1'b0);
    wait_until(a0 + 18);
    check("ready_after_take", code_ready, 1'b1);
    w = char_v;
    check("char_row0", w[0:15], 16'hA5A5);
    check("char_row1", w[16:31], 16'hA5A4);
    check("char_row15", w[240:255], 16'hA5AA);
    wait_until(a0 + 280);
    check("idle_busy", busy, 1'b0);

    // back-to-back with a third code held off by backpressure
    send(8'h41, a0);
    push(8'h41, a0 + 18);
    send(8'h42, a1);
    check("b2b_accept2", a1, a0 + 19);
    push(8'h42, a0 + 274);
    send(8'h43, a2);
    code_valid = 1'b0;
    check("bp_accept3", a2, a0 + 275);
    push(8'h43, a0 + 530);
    wait_until(a0 + 800);

    // reset mid-display
    send(8'h44, a0);
    code_valid = 1'b0;
    push(8'h44, a0 + 18);
    wait_until(a0 + 118);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstd_printable", printable, 1'b0);
    check("rstd_char", char_v, 256'h0);
    check("rstd_busy", busy, 1'b0);
    check("rstd_ready", code_ready, 1'b1);
    send(8'h45, a0);
    code_valid = 1'b0;
    push(8'h45, a0 + 18);
    wait_until(a0 + 280);

    // reset mid-fetch
    send(8'h55, a0);
    code_valid = 1'b0;
    wait_until(a0 + 7);
    check("rstf_row7", rom_addr, 12'h557);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstf_rom_addr", rom_addr, 12'h000);
    check("rstf_busy", busy, 1'b0);
    send(8'h46, a0);
    code_valid = 1'b0;
    push(8'h46, a0 + 18);
    wait_until(a0 + 280);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
